// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one asynchronous-FIFO write port among
// NUM_REQ requesters on the write clock domain. Each grant covers a burst
// of at most MAX_BURST accepted words, and w_full backpressure is honoured.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                             w_clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic                             w_full,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               accept,
  output logic                             w_en,
  output logic [DATA_WIDTH-1:0]            w_data,
  output logic                             busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               sel_req;

  // First requesting index at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin : pick_scan
    logic [IDX_W-1:0] cand;
    cand       = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Write-port steering: the one-hot grant selects the data slice and strobe.
  always_comb begin
    accept  = '0;
    w_data  = '0;
    sel_req = 1'b0;
    if (state == GRANT) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          w_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
          accept[i] = req[i] & ~w_full;
          sel_req   = req[i];
        end
      end
    end
    w_en = |accept;
  end

  assign busy = (state == GRANT);

  // Next-state logic: grant from IDLE, release on burst end or dropped request.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = GRANT;
          grant_nxt = NUM_REQ'(1) << pick_idx;
          cnt_nxt   = '0;
          ptr_nxt   = IDX_W'((32'(pick_idx) + 1) % NUM_REQ);
        end
      end
      GRANT: begin
        if (!sel_req || (w_en && (cnt == LAST_BEAT))) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          cnt_nxt   = '0;
        end else if (w_en) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any burst.
  always_ff @(posedge w_clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter with a behavioural reference model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int OW = 2*N + DW + 2;
  localparam int STARVE_MAX = (N-1)*(MB+1) + 1;

  logic              w_clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic              w_full = 1'b0;
  logic [N-1:0]      grant, accept;
  logic              w_en;
  logic [DW-1:0]     w_data;
  logic              busy;

  int passed = 0;
  int total  = 0;

  // Reference model: granted requester (-1 when idle), beats taken, pointer.
  int m_g = -1;
  int m_beats = 0;
  int m_ptr = 0;

  always #5 w_clk = ~w_clk;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .w_clk(w_clk), .rst(rst), .req(req), .req_data(req_data), .w_full(w_full),
    .grant(grant), .accept(accept), .w_en(w_en), .w_data(w_data), .busy(busy)
  );

  wire [OW-1:0] obs = {grant, accept, w_en, w_data, busy};

  function automatic logic [OW-1:0] model_outs();
    logic [N-1:0]  g = '0;
    logic [N-1:0]  a = '0;
    logic [DW-1:0] d = '0;
    logic          e = 1'b0;
    if (m_g >= 0) begin
      g[m_g] = 1'b1;
      d      = req_data[m_g*DW +: DW];
      a[m_g] = req[m_g] & ~w_full;
      e      = a[m_g];
    end
    return {g, a, e, d, (m_g >= 0)};
  endfunction

  // Advance one clock edge and apply the arbitration rules to the model.
  task automatic tick();
    @(posedge w_clk);
    if (rst) begin
      m_g = -1; m_beats = 0; m_ptr = 0;
    end else if (m_g < 0) begin
      for (int k = 0; k < N; k++)
        if (m_g < 0 && req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      if (m_g >= 0) begin
        m_beats = 0;
        m_ptr   = (m_g + 1) % N;
      end
    end else begin
      if (req[m_g] && !w_full) m_beats++;
      if (!req[m_g] || m_beats == MB) begin
        m_g = -1; m_beats = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; w_full = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '1; w_full = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      req_data = $urandom();
      #2;
      total++;
      if (obs !== model_outs() || grant !== '0 || w_en !== 1'b0 || busy !== 1'b0)
        $display("FAIL reset_hold outs got %h exp %h", obs, model_outs());
      else passed++;
      tick();
    end
    rst = 1'b0;
    #2;
    total++;
    if (obs !== model_outs() || grant !== '0) $display("FAIL reset_release outs got %h exp %h", obs, model_outs());
    else passed++;
    tick();
    #2;
    total++;
    if (obs !== model_outs() || grant !== 4'b0001) $display("FAIL reset_first_grant grant got %b exp 0001", grant);
    else passed++;
    tick();
  endtask

  task automatic test_rotation();
    int seq[$];
    int lens[$];
    int run = 0;
    logic [N-1:0] prev = '0;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = '1; w_full = 1'b0;
    for (int c = 0; c < 25; c++) begin
      req_data = $urandom();
      #2;
      total++;
      if (obs !== model_outs()) $display("FAIL rotation_outs cyc %0d got %h exp %h", c, obs, model_outs());
      else passed++;
      if (grant !== prev) begin
        if (prev !== '0) lens.push_back(run);
        if (grant !== '0) seq.push_back(onehot_idx(grant));
        run = 0;
      end
      if (w_en) run++;
      prev = grant;
      tick();
    end
    total++;
    if (seq.size() != 5) $display("FAIL rotation_count got %0d exp 5", seq.size());
    else passed++;
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
      total++;
      if (seq[i] != exp_seq[i]) $display("FAIL rotation_order[%0d] got %0d exp %0d", i, seq[i], exp_seq[i]);
      else passed++;
    end
    for (int i = 0; i < lens.size(); i++) begin
      total++;
      if (lens[i] != MB) $display("FAIL rotation_burst[%0d] got %0d exp %0d", i, lens[i], MB);
      else passed++;
    end
  endtask

  task automatic test_early_release();
    int writes = 0;
    int extra = 0;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20 && writes < 2; c++) begin
      req_data = $urandom();
      #2;
      total++;
      if (obs !== model_outs()) $display("FAIL early_outs got %h exp %h", obs, model_outs());
      else passed++;
      if (w_en) writes++;
      tick();
    end
    total++;
    if (writes != 2) $display("FAIL early_writes got %0d exp 2", writes);
    else passed++;
    req = '0;
    #2;
    total++;
    if (grant !== 4'b0100 || w_en !== 1'b0) $display("FAIL early_hold grant got %b exp 0100 w_en %b", grant, w_en);
    else passed++;
    tick();
    for (int c = 0; c < 3; c++) begin
      #2;
      total++;
      if (obs !== model_outs() || grant !== '0) $display("FAIL early_cleared got %h exp %h", obs, model_outs());
      else passed++;
      if (w_en) extra++;
      tick();
    end
    total++;
    if (extra != 0) $display("FAIL early_extra_writes got %0d exp 0", extra);
    else passed++;
    req = 4'b1001;
    tick();
    #2;
    total++;
    if (obs !== model_outs() || grant !== 4'b1000) $display("FAIL early_pointer grant got %b exp 1000", grant);
    else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    int writes = 0;
    bit released = 0;
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20 && writes < 2; c++) begin
      req_data = $urandom();
      #2;
      total++;
      if (obs !== model_outs()) $display("FAIL bp_start got %h exp %h", obs, model_outs());
      else passed++;
      if (w_en) writes++;
      tick();
    end
    w_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_data = $urandom();
      #2;
      total++;
      if (obs !== model_outs() || w_en !== 1'b0 || accept !== '0 || grant !== 4'b0010)
        $display("FAIL bp_stall cyc %0d got %h exp %h", c, obs, model_outs());
      else passed++;
      tick();
    end
    w_full = 1'b0;
    writes = 0;
    for (int c = 0; c < 10 && !released; c++) begin
      req_data = $urandom();
      #2;
      total++;
      if (obs !== model_outs()) $display("FAIL bp_resume got %h exp %h", obs, model_outs());
      else passed++;
      if (grant === '0) released = 1;
      else begin
        if (w_en) writes++;
        tick();
      end
    end
    total++;
    if (!released || writes != 2) $display("FAIL bp_remaining writes got %0d exp 2 released %0d", writes, released);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int writes = 0;
    do_reset();
    req = '1;
    for (int c = 0; c < 20 && writes < 2; c++) begin
      req_data = $urandom();
      #2;
      if (w_en) writes++;
      tick();
    end
    rst = 1'b1;
    #2;
    total++;
    if (obs !== model_outs() || w_en !== 1'b1) $display("FAIL midrst_beat3 got %h exp %h", obs, model_outs());
    else passed++;
    tick();
    rst = 1'b0;
    #2;
    total++;
    if (obs !== model_outs() || grant !== '0 || w_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_cleared got %h exp %h", obs, model_outs());
    else passed++;
    tick();
    #2;
    total++;
    if (obs !== model_outs() || grant !== 4'b0001) $display("FAIL midrst_pointer grant got %b exp 0001", grant);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    int waitc[N];
    int worst;
    do_reset();
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_g == i) begin
          if ($urandom_range(7) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          req[i] = ($urandom_range(2) == 0);
        end
      end
      w_full   = ($urandom_range(3) == 0);
      req_data = $urandom();
      #2;
      total++;
      if (obs !== model_outs()) $display("FAIL random_outs cyc %0d got %h exp %h", c, obs, model_outs());
      else passed++;
      total++;
      if ((w_en & w_full) !== 1'b0 || !$onehot0(grant))
        $display("FAIL random_safety cyc %0d w_en %b w_full %b grant %b", c, w_en, w_full, grant);
      else passed++;
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (m_g == i || !req[i]) waitc[i] = 0;
        else if (!w_full) waitc[i]++;
        if (waitc[i] > worst) worst = waitc[i];
      end
      total++;
      if (worst > STARVE_MAX) $display("FAIL random_starve cyc %0d wait %0d limit %0d", c, worst, STARVE_MAX);
      else passed++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_early_release();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
